// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ==== mips_mem_pkg : shared types for the IF/DM memory-port arbiter ====
// Rev 1.0
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_DM = 1'b0,
    OWN_IF = 1'b1
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_timer.sv
`default_nettype none
// ==== mem_latency_timer : load/decrement counter, done when it reaches zero ====
// Rev 1.0
module mem_latency_timer #(
  parameter int MEM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ==== mem_port_arbiter : shares the single-port data memory between IF and DM ====
// Rev 1.0
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  generate
    if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
    end
  endgenerate

  arb_state_t      state, state_nxt;
  arb_owner_t      owner;
  logic [SC_W-1:0] starve_cnt;
  logic            acc_we;
  logic            take, grant_if, grant_dm, lat_done, access_done;
  logic            if_gnt_d, dm_gnt_d, mem_read_d, mem_write_d, if_rvalid_d, dm_rvalid_d;

  // DM wins ties until fetch has lost STARVE_LIMIT cycles in a row
  assign take     = (state == IDLE) && (if_req || dm_req);
  assign grant_if = take && if_req && (!dm_req || (starve_cnt == STARVE_MAX));
  assign grant_dm = take && !grant_if;

  mem_latency_timer #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (state == ISSUE),
    .done (lat_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    access_done = (state == WAIT) && lat_done;
    if_gnt_d    = grant_if;
    dm_gnt_d    = grant_dm;
    mem_read_d  = grant_if || (grant_dm && !dm_we);
    mem_write_d = grant_dm && dm_we;
    if_rvalid_d = access_done && (owner == OWN_IF);
    dm_rvalid_d = access_done && (owner == OWN_DM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      busy       <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWN_DM;
      acc_we     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      if_rvalid <= if_rvalid_d;
      dm_rvalid <= dm_rvalid_d;
      busy      <= (state_nxt != IDLE);

      if (take) begin
        owner     <= grant_if ? OWN_IF : OWN_DM;
        acc_we    <= grant_dm && dm_we;
        mem_addr  <= grant_if ? if_addr : dm_addr;
        mem_wdata <= (grant_dm && dm_we) ? dm_wdata : '0;
      end else if (state == ISSUE) begin
        mem_wdata <= '0;
      end

      if (if_rvalid_d) if_rdata <= mem_rdata;
      if (dm_rvalid_d) dm_rdata <= acc_we ? '0 : mem_rdata;

      if (grant_if) begin
        starve_cnt <= '0;
      end else if (if_req && (starve_cnt != STARVE_MAX) &&
                   (grant_dm || ((state != IDLE) && (owner == OWN_DM)))) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ==== tb_mem_port_arbiter : directed table, corner sequences, random run vs transaction model ====
// Rev 1.0
module tb_mem_port_arbiter;

  localparam int LAT    = 1;
  localparam int SLIM   = 4;
  localparam int N_RAND = 10000;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_read, mem_write, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        if_req3;
  logic [31:0] if_addr3;
  logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_read3, mem_write3, busy3;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(SLIM)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'd0), .dm_wdata(32'd0),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Latency-3 instance sees a value that changes every cycle, exposing the exact capture edge
  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign mem_rdata3 = {16'h5A00, cyc[15:0]};

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  logic [31:0] mem [32];
  logic [31:0] rd_q;
  logic        mem_fill;
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
    rd_q <= mem_read ? mem[mem_addr[4:0]] : 32'hBADB_AD00;
  end
  assign mem_rdata = rd_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_read, mem_write, busy}, 64'd0);
    check({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'd0);
    check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clk);
    check($sformatf("txn%0d_gnt", idx), {if_gnt, dm_gnt}, v.is_dm ? 2'b01 : 2'b10);
    check($sformatf("txn%0d_strobe", idx), {mem_read, mem_write}, (v.is_dm && v.we) ? 2'b01 : 2'b10);
    check($sformatf("txn%0d_addr", idx), mem_addr, v.addr);
    if (v.is_dm && v.we) check($sformatf("txn%0d_wdata", idx), mem_wdata, v.wdata);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    check($sformatf("txn%0d_wait", idx),
          {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_read, mem_write, busy}, 7'b0000001);
    @(negedge clk);
    check($sformatf("txn%0d_rvalid", idx), {if_rvalid, dm_rvalid, busy}, v.is_dm ? 3'b010 : 3'b100);
    check($sformatf("txn%0d_rdata", idx), v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
  endtask

  task automatic tie_check(input string tag);
    if_req = 1'b1; if_addr = 32'd7; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd31;
    @(negedge clk);
    check({tag, "_dm_gnt"}, {if_gnt, dm_gnt}, 2'b01);
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_dm_rvalid"}, {if_gnt, dm_rvalid, dm_rdata}, {1'b0, 1'b1, 32'h1234_5678});
    @(negedge clk);
    check({tag, "_if_gnt"}, {if_gnt, dm_gnt}, 2'b10);
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_if_rvalid"}, {if_rvalid, if_rdata}, {1'b1, init_word(7)});
  endtask

  // Transaction-level reference: each access occupies the port for LAT+2 cycles
  task automatic run_random();
    logic [31:0] ref_mem [32];
    int          free_at, done_at, starve, n_gnt, n_rv;
    logic        m_if_owner, win_if, idle, prev_busy, e_chk_issue;
    logic [31:0] m_data, e_if_rdata, e_dm_rdata, e_addr, e_wdata;
    logic [6:0]  e_ctl, n_ctl;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    free_at = 0; done_at = -1; starve = 0; n_gnt = 0; n_rv = 0;
    m_if_owner = 1'b0; m_data = '0; e_if_rdata = '0; e_dm_rdata = '0;
    e_ctl = '0; e_addr = '0; e_wdata = '0; e_chk_issue = 1'b0; prev_busy = 1'b0;
    for (int t = 0; t < N_RAND; t++) begin
      check("rand_ctl", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, busy, mem_read, mem_write}, e_ctl);
      check("rand_if_rdata", if_rdata, e_if_rdata);
      check("rand_dm_rdata", dm_rdata, e_dm_rdata);
      check("rand_overlap", mem_read & mem_write, 1'b0);
      check("rand_gnt_busy", (if_gnt | dm_gnt) & prev_busy, 1'b0);
      if (e_chk_issue) check("rand_issue", {mem_addr, mem_wdata}, {e_addr, e_wdata});
      n_gnt += int'(if_gnt) + int'(dm_gnt);
      n_rv  += int'(if_rvalid) + int'(dm_rvalid);
      prev_busy = busy;

      if (t < N_RAND - 8) begin
        if (!if_req || if_gnt) begin
          if_req  = ($urandom % 3) == 0;
          if_addr = $urandom;
        end
        if (!dm_req || dm_gnt) begin
          dm_req   = ($urandom % 2) == 0;
          dm_we    = $urandom % 2;
          dm_addr  = $urandom;
          dm_wdata = $urandom;
        end
      end else begin
        if_req = 1'b0; dm_req = 1'b0;
      end

      idle  = (t >= free_at);
      n_ctl = '0;
      e_chk_issue = 1'b0;
      if (t == done_at) begin
        if (m_if_owner) begin n_ctl[4] = 1'b1; e_if_rdata = m_data; end
        else begin n_ctl[3] = 1'b1; e_dm_rdata = m_data; end
      end
      if (idle && (if_req || dm_req)) begin
        win_if = if_req && (!dm_req || starve == SLIM);
        e_chk_issue = 1'b1;
        e_wdata = '0;
        if (win_if) begin
          n_ctl[6] = 1'b1; n_ctl[1] = 1'b1;
          e_addr = if_addr; m_data = ref_mem[if_addr[4:0]];
          starve = 0;
        end else begin
          n_ctl[5] = 1'b1; e_addr = dm_addr;
          if (dm_we) begin
            n_ctl[0] = 1'b1; e_wdata = dm_wdata;
            ref_mem[dm_addr[4:0]] = dm_wdata; m_data = '0;
          end else begin
            n_ctl[1] = 1'b1; m_data = ref_mem[dm_addr[4:0]];
          end
          if (if_req && starve < SLIM) starve++;
        end
        m_if_owner = win_if;
        free_at = t + 2 + LAT;
        done_at = t + 1 + LAT;
      end else if (!idle && if_req && !m_if_owner && starve < SLIM) begin
        starve++;
      end
      n_ctl[2] = (t + 1 < free_at);
      e_ctl = n_ctl;
      @(negedge clk);
    end
    check("rand_rvalid_per_gnt", n_rv, n_gnt);
  endtask

  initial begin
    vec_t        tbl [9];
    int          ndm, ioff, goff, roff;
    logic [31:0] c0, tmp, got;

    reset = 1'b1; mem_fill = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0;

    tbl[0] = '{1'b1, 1'b1, 32'd5,         32'hDEAD_BEEF, 32'd0};
    tbl[1] = '{1'b1, 1'b0, 32'd5,         32'd0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 1'b0, 32'd5,         32'd0,         32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b1, 32'd31,        32'h1234_5678, 32'd0};
    tbl[4] = '{1'b0, 1'b0, 32'd31,        32'd0,         32'h1234_5678};
    tbl[5] = '{1'b1, 1'b1, 32'h25,        32'hCAFE_F00D, 32'd0};
    tbl[6] = '{1'b1, 1'b0, 32'd5,         32'd0,         32'hCAFE_F00D};
    tbl[7] = '{1'b0, 1'b0, 32'hFFFF_FFE2, 32'd0,         init_word(2)};
    tbl[8] = '{1'b1, 1'b0, 32'd0,         32'd0,         init_word(0)};

    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0; mem_fill = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, if_gnt, dm_gnt, if_rvalid, dm_rvalid}, 5'd0);

    for (int i = 0; i < 9; i++) do_txn(i, tbl[i]);

    tie_check("tie");

    // Both requesters held: fetch must get in after the second DM completion
    if_req = 1'b1; if_addr = 32'd3; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd31;
    ndm = 0; ioff = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dm_gnt) ndm++;
      if (if_gnt) begin ioff = k; break; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("starve_dm_count", ndm, 2);
    check("starve_if_gnt_cycle", ioff, 7);
    repeat (2) @(negedge clk);
    check("starve_if_rvalid", {if_rvalid, if_rdata}, {1'b1, init_word(3)});
    tie_check("tie_after_starve");

    // Reset in the middle of an outstanding read
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd5;
    @(negedge clk);
    dm_req = 1'b0;
    @(negedge clk);
    check("midwait_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_zero("rst_midwait");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_rvalid", {if_rvalid, dm_rvalid, busy, if_gnt, dm_gnt}, 5'd0);
    end

    // MEM_LATENCY=3 instance
    c0 = cyc; if_req3 = 1'b1; if_addr3 = 32'd2; goff = -1; roff = -1; got = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (if_gnt3) begin
        goff = k; if_req3 = 1'b0;
        check("lat3_strobe", {mem_read3, mem_write3, mem_addr3}, {1'b1, 1'b0, 32'd2});
      end
      if (if_rvalid3) begin roff = k; got = if_rdata3; break; end
    end
    if_req3 = 1'b0;
    tmp = c0 + 32'd4;
    check("lat3_gnt_cycle", goff, 1);
    check("lat3_rvalid_cycle", roff, 5);
    check("lat3_rdata", got, {16'h5A00, tmp[15:0]});
    check("lat3_dm_side", {dm_gnt3, dm_rvalid3, busy3, dm_rdata3, mem_wdata3}, 64'd0);

    @(negedge clk);
    reset = 1'b1; mem_fill = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_fill = 1'b0;
    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
